imem_dmem_arbiter: RTL

- Shares one memory port between the CPU's instruction-fetch (IF) requester and load/store (D) requester.
- Serialises accesses with valid/ready handshakes and keeps at most one memory transaction outstanding.
- Data accesses have fixed priority; a starvation guard forces an IF grant periodically.
- Sits between the CPU core and the unified instruction/data memory model.

---
 rtl/imem_dmem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters.
// One transaction in flight; data has priority, IF is forced after STARVE_MAX D grants.
`timescale 1ns/1ps
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                busy,
    output logic                grant_owner
);
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SW-1:0]     wstrb_q;
    logic              if_rsp_valid_q, d_rsp_valid_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              sel_d, sel_if, idle;

    assign idle = (state_q == IDLE);

    // IF wins a contested cycle only once the starvation count saturates
    always_comb begin
        sel_d  = d_req_valid && !(if_req_valid && starve_q == 4'(STARVE_MAX));
        sel_if = if_req_valid && !sel_d;
    end

    always_comb begin
        starve_d = starve_q;
        if (idle && sel_if) begin
            starve_d = '0;
        end else if (idle && sel_d && if_req_valid
                     && starve_q != 4'(STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_if || sel_d) state_d = ISSUE;
            ISSUE:   if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if_req_ready = rst_n && sel_if;
                d_req_ready  = rst_n && sel_d;
            end
            ISSUE:   mem_req_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if_rdata_q     <= '0;
            d_rdata_q      <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if (idle && sel_d) begin
                owner_q <= 1'b1;
                we_q    <= d_req_we;
                addr_q  <= d_req_addr;
                wdata_q <= d_req_wdata;
                wstrb_q <= d_req_wstrb;
            end else if (idle && sel_if) begin
                owner_q <= 1'b0;
                we_q    <= 1'b0;
                addr_q  <= if_req_addr;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
            if (state_q == WAIT && mem_rsp_valid) begin
                if (owner_q) begin
                    d_rsp_valid_q <= 1'b1;
                    d_rdata_q     <= we_q ? '0 : mem_rsp_rdata;
                end else begin
                    if_rsp_valid_q <= 1'b1;
                    if_rdata_q     <= mem_rsp_rdata;
                end
            end
        end
    end

    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_rdata  = if_rdata_q;
    assign d_rsp_valid   = d_rsp_valid_q;
    assign d_rsp_rdata   = d_rdata_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign busy          = !idle;
    assign grant_owner   = owner_q;
endmodule
